// File: rtl/multdiv_pkg.sv
// ============================================================================
// Module      : multdiv_pkg
// Description : Shared types and constants for the iterative mult/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multdiv_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_ITERS = 32;

    // One extra bit so the counter can sit at ITERS for the fix-up cycle.
    localparam int CNT_W = $clog2(DEF_ITERS) + 1;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] ZERO    = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : multdiv_pkg

`default_nettype wire

// File: rtl/multdiv_if.sv
// ============================================================================
// Module      : multdiv_if
// Description : Operand/control/result bundle between execute stage and the
//               iterative mult/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multdiv_if
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic             ctrl_mult;
    logic             ctrl_div;
    logic [WIDTH-1:0] result;
    logic             result_ready;
    logic             exception;
    logic             busy;

    modport master (
        output operandA, operandB, ctrl_mult, ctrl_div,
        input  result, result_ready, exception, busy
    );

    modport slave (
        input  operandA, operandB, ctrl_mult, ctrl_div,
        output result, result_ready, exception, busy
    );
endinterface : multdiv_if

`default_nettype wire

// File: rtl/multdiv_addsub.sv
// ============================================================================
// Module      : multdiv_addsub
// Description : WIDTH+1-bit adder/subtractor with carry-out. When subtracting,
//               cout_o=1 means no borrow (a_i >= b_i, unsigned).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_addsub
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  wire logic [WIDTH:0] a_i,
    input  wire logic [WIDTH:0] b_i,
    input  wire logic           sub_i,
    output logic      [WIDTH:0] sum_o,
    output logic                cout_o
);

    logic [WIDTH:0] b_eff;

    assign b_eff = sub_i ? ~b_i : b_i;
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff}
                           + {{(WIDTH+1){1'b0}}, sub_i};

endmodule : multdiv_addsub

`default_nettype wire

// File: rtl/multdiv_iter.sv
// ============================================================================
// Module      : multdiv_iter
// Description : Iterative signed multiply / divide, one operand bit per clock.
//               Shift-add multiply and restoring divide on magnitudes, then a
//               sign fix-up cycle. Fixed latency of ITERS+1 edges.
//               Optional: MULTDIV_OVF_EXC_EN adds signed-overflow exceptions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_iter
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ITERS = DEF_ITERS
) (
    input  wire logic clock,
    input  wire logic clear,
    multdiv_if.slave  bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;       // product high word / remainder
    logic [WIDTH-1:0] lo_q, lo_d;       // multiplier->product low / dividend->quotient
    logic [WIDTH-1:0] opb_q, opb_d;     // multiplicand or divisor magnitude
    logic             neg_q, neg_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;

    logic [WIDTH:0]   as_a, as_b, as_sum;
    logic             as_sub, as_cout;
    logic             last;
    logic             start_ok;
    logic [WIDTH-1:0] mag_a, mag_b;

    // Counter parked at ITERS marks the sign fix-up cycle.
    assign last     = (cnt_q == CNT_W'(ITERS));
    assign start_ok = bus.ctrl_mult ^ bus.ctrl_div;
    // Unary minus of the most negative value yields its unsigned magnitude.
    assign mag_a    = bus.operandA[WIDTH-1] ? -bus.operandA : bus.operandA;
    assign mag_b    = bus.operandB[WIDTH-1] ? -bus.operandB : bus.operandB;

    multdiv_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a_i    (as_a),
        .b_i    (as_b),
        .sub_i  (as_sub),
        .sum_o  (as_sum),
        .cout_o (as_cout)
    );

    // Steer the shared adder: accumulate, trial-subtract, or final negate.
    always_comb begin
        as_a   = {1'b0, hi_q};
        as_b   = {1'b0, opb_q};
        as_sub = 1'b0;
        if (last) begin
            as_a   = '0;
            as_b   = {1'b0, lo_q};
            as_sub = 1'b1;
        end else if (state_q == DIV) begin
            as_a   = {hi_q, lo_q[WIDTH-1]};
            as_sub = 1'b1;
        end
    end

    // Next-state, datapath update and output registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        zero_d   = zero_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        busy_d   = busy_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start_ok) begin
                    state_d = bus.ctrl_mult ? MUL : DIV;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = bus.ctrl_mult ? mag_b : mag_a;
                    opb_d   = bus.ctrl_mult ? mag_a : mag_b;
                    neg_d   = bus.operandA[WIDTH-1] ^ bus.operandB[WIDTH-1];
                    zero_d  = (bus.operandB == '0);
                    busy_d  = 1'b1;
                end
            end
            MUL: begin
                if (!last) begin
                    if (lo_q[0]) begin
                        hi_d = as_sum[WIDTH:1];
                        lo_d = {as_sum[0], lo_q[WIDTH-1:1]};
                    end else begin
                        hi_d = {1'b0, hi_q[WIDTH-1:1]};
                        lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d  = DONE;
                    rdy_d    = 1'b1;
                    busy_d   = 1'b0;
                    result_d = neg_q ? as_sum[WIDTH-1:0] : lo_q;
`ifdef MULTDIV_OVF_EXC_EN
                    exc_d    = (hi_q != '0) ||
                               (lo_q[WIDTH-1] && !(neg_q && lo_q == WIDTH'(INT_MIN)));
`else
                    exc_d    = 1'b0;
`endif
                end
            end
            DIV: begin
                if (!last) begin
                    if (as_cout) begin
                        hi_d = as_sum[WIDTH-1:0];
                    end else begin
                        hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                    end
                    lo_d  = {lo_q[WIDTH-2:0], as_cout};
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d  = DONE;
                    rdy_d    = 1'b1;
                    busy_d   = 1'b0;
                    if (zero_q) begin
                        result_d = WIDTH'(ZERO);
                    end else begin
                        result_d = neg_q ? as_sum[WIDTH-1:0] : lo_q;
                    end
`ifdef MULTDIV_OVF_EXC_EN
                    exc_d    = zero_q || (!neg_q && lo_q == WIDTH'(INT_MIN));
`else
                    exc_d    = zero_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; clear aborts any operation immediately.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.result       = result_q;
    assign bus.exception    = exc_q;
    assign bus.result_ready = rdy_q;
    assign bus.busy         = busy_q;

endmodule : multdiv_iter

`default_nettype wire

// File: tb/tb_multdiv_iter.sv
// ============================================================================
// Module      : tb_multdiv_iter
// Description : Self-checking bench for multdiv_iter: arithmetic reference
//               model with per-cycle compare plus directed literal checks.
//               Honours MULTDIV_OVF_EXC_EN for the overflow expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multdiv_iter;

    localparam logic [31:0] T_INT_MIN = 32'h8000_0000;
`ifdef MULTDIV_OVF_EXC_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    multdiv_if #(.WIDTH(32)) bus ();

    multdiv_iter #(.WIDTH(32), .ITERS(32)) dut (
        .clock (clk),
        .clear (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result {exception, result} straight from signed arithmetic.
    function automatic logic [32:0] model_op(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        is_mul);
        longint p;
        logic [31:0] r;
        logic        e;
        if (is_mul) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = OVF_EN && (p != longint'($signed(r)));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == T_INT_MIN && b == 32'hFFFF_FFFF) begin
            r = T_INT_MIN;
            e = OVF_EN;
        end else begin
            p = longint'($signed(a)) / longint'($signed(b));
            r = p[31:0];
            e = 1'b0;
        end
        return {e, r};
    endfunction

    // Timing model: a countdown from the accepting edge to the done edge.
    int          m_cd;
    logic        m_busy, m_rdy, m_exc;
    logic [31:0] m_res;
    logic [32:0] pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cd   <= 0;
            m_busy <= 1'b0;
            m_rdy  <= 1'b0;
            m_res  <= 32'd0;
            m_exc  <= 1'b0;
        end else begin
            m_rdy <= 1'b0;
            if (m_cd > 0) begin
                m_cd <= m_cd - 1;
                if (m_cd == 1) begin
                    m_res  <= pend[31:0];
                    m_exc  <= pend[32];
                    m_rdy  <= 1'b1;
                    m_busy <= 1'b0;
                end
            end else if (bus.ctrl_mult ^ bus.ctrl_div) begin
                pend   <= model_op(bus.operandA, bus.operandB, bus.ctrl_mult);
                m_cd   <= 33;
                m_busy <= 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc busy",      32'(bus.busy),         32'(m_busy));
            chk("cyc ready",     32'(bus.result_ready), 32'(m_rdy));
            chk("cyc result",    bus.result,            m_res);
            chk("cyc exception", 32'(bus.exception),    32'(m_exc));
        end
    end

    // Present a one-cycle start pulse; called at a falling edge.
    task automatic start(input logic [31:0] a, input logic [31:0] b,
                         input logic m, input logic d);
        bus.operandA  = a;
        bus.operandB  = b;
        bus.ctrl_mult = m;
        bus.ctrl_div  = d;
        @(negedge clk);
        bus.ctrl_mult = 1'b0;
        bus.ctrl_div  = 1'b0;
    endtask

    // Wait (bounded) for result_ready; lat counts falling edges since the start.
    task automatic wait_ready(input int lat0, input string nm,
                              input logic [31:0] er, input logic ee);
        int lat;
        lat = lat0;
        while (!bus.result_ready && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"},   32'(lat), 32'd34);
        chk({nm, " result"},    bus.result, er);
        chk({nm, " exception"}, 32'(bus.exception), 32'(ee));
    endtask

    initial begin
        int seen;
        rst           = 1'b1;
        bus.operandA  = '0;
        bus.operandB  = '0;
        bus.ctrl_mult = 1'b0;
        bus.ctrl_div  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset result",    bus.result,               32'd0);
        chk("reset ready",     32'(bus.result_ready),    32'd0);
        chk("reset exception", 32'(bus.exception),       32'd0);
        chk("reset busy",      32'(bus.busy),            32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 7 * -3
        start(32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0);
        chk("mul busy early", 32'(bus.busy), 32'd1);
        wait_ready(1, "mul 7*-3", 32'hFFFF_FFEB, 1'b0);
        @(negedge clk);
        chk("mul ready pulse", 32'(bus.result_ready), 32'd0);
        chk("mul hold",        bus.result, 32'hFFFF_FFEB);

        // -100 / 7
        start(32'hFFFF_FF9C, 32'd7, 1'b0, 1'b1);
        wait_ready(1, "div -100/7", 32'hFFFF_FFF2, 1'b0);

        // 5 / 0
        start(32'd5, 32'd0, 1'b0, 1'b1);
        wait_ready(1, "div 5/0", 32'd0, 1'b1);

        // 2^16 * 2^16 overflows
        start(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);
        wait_ready(1, "mul ovf", 32'd0, OVF_EN);

        // -2^31 / -1 wraps
        start(T_INT_MIN, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_ready(1, "div min/-1", T_INT_MIN, OVF_EN);

        // -2^31 * 1 fits exactly
        start(T_INT_MIN, 32'd1, 1'b1, 1'b0);
        wait_ready(1, "mul min*1", T_INT_MIN, 1'b0);

        // Both starts together: ignored
        @(negedge clk);
        start(32'd9, 32'd9, 1'b1, 1'b1);
        chk("both busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);

        // Pulse during MUL ignored, restart in DONE accepted
        start(32'd6, 32'd7, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        start(32'd84, 32'd2, 1'b0, 1'b1);
        wait_ready(10, "mul 6*7", 32'd42, 1'b0);
        start(32'd84, 32'd2, 1'b0, 1'b1);
        wait_ready(1, "div 84/2", 32'd42, 1'b0);

        // Clear mid-divide
        @(negedge clk);
        start(32'd1000, 32'd10, 1'b0, 1'b1);
        repeat (13) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("clear result", bus.result,         32'd0);
        chk("clear busy",   32'(bus.busy),      32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.result_ready) seen++;
        end
        chk("no ready after clear", 32'(seen), 32'd0);
        start(32'd3, 32'd3, 1'b1, 1'b0);
        wait_ready(1, "mul 3*3", 32'd9, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_multdiv_iter

`default_nettype wire

// File: doc/multdiv_iter.md
Name: multdiv_iter

Overview:
- Iterative signed 32-bit multiply/divide unit in the processor execute path.
- Produces one result per operation and feeds the 32-bit result/writeback register, which captures `result` when `result_ready` is high.
- Processes one operand bit per cycle, so latency is fixed regardless of operand values.
- Holds the last result stable until the next operation starts.

Parameters:
- WIDTH, 32, operand and result width in bits.
- ITERS, 32, iteration count; must equal WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- clear  input  1  reset, asynchronous, active-high; forces IDLE and zeroes all state and outputs.
- operandA  input  WIDTH  multiplicand / dividend, two's complement.
- operandB  input  WIDTH  multiplier / divisor, two's complement.
- ctrl_mult  input  1  start-multiply pulse; sampled only when accepting.
- ctrl_div  input  1  start-divide pulse; sampled only when accepting.
- result  output  WIDTH  product low word or quotient.
- result_ready  output  1  one-cycle pulse; result valid.
- exception  output  1  error flag, valid with result_ready and held with result.
- busy  output  1  high while an operation is in progress.

Behaviour:
- Reset values: result=0, result_ready=0, exception=0, busy=0, state=IDLE, counter=0.
- States:
  - IDLE: waits for a start pulse.
  - MUL: shift-add on magnitudes, 2*WIDTH-bit accumulator.
  - DIV: restoring division on magnitudes.
  - DONE: sign fix-up and output.
- Accepting: the unit accepts a start pulse in IDLE or DONE.
  - Exactly one of ctrl_mult/ctrl_div high latches operandA/operandB, clears the counter and enters MUL or DIV.
  - busy goes high the cycle after the accepting edge.
  - Both high together is illegal: ignored, no state change.
- Pulses during MUL/DIV are ignored; the operation in flight is not disturbed.
- Iteration: one bit per clock; counter 0..ITERS-1. On counter==ITERS-1, the next edge enters DONE.
- Latency: the start is sampled at edge E0. The DONE edge is E0+ITERS+1 (=33). result, exception and result_ready=1 are registered at that edge. result_ready is high for exactly one cycle; busy drops at the same edge.
- DONE lasts one cycle, then IDLE unless a new start is accepted in DONE; that restart is allowed while result_ready is high.
- result and exception hold until the next DONE edge or clear.
- Multiply: result = low WIDTH bits of the signed product. The sign is negated at the end if operand signs differ.
- Divide:
  - Quotient truncates toward zero; the remainder is discarded.
  - Quotient sign = XOR of operand signs.
  - Divisor 0: full latency still elapses, result=0, exception=1.
  - -2^31 / -1: result=0x80000000 (wraps).
- Magnitude of -2^31 is handled as the unsigned 0x80000000, with no loss.
- Reset during MUL/DIV: immediate abort, outputs zeroed; no result_ready is emitted for the aborted operation.

Optional Feature:
- Macro: MULTDIV_OVF_EXC_EN.
- Defined:
  - Multiply sets exception=1 when the full signed product does not fit in WIDTH bits, i.e. the upper word is not the sign-extension of result[WIDTH-1].
  - Divide sets exception=1 for -2^31 / -1.
  - The result value is unchanged.
- Undefined: exception is raised only for divide-by-zero; no overflow detection logic is synthesized.

Decomposition:
- Package multdiv_pkg:
  - state encoding IDLE/MUL/DIV/DONE.
  - WIDTH and ITERS defaults.
  - counter width $clog2(ITERS)+1.
  - constants INT_MIN=0x80000000 and ZERO.
- Sub-module multdiv_addsub: a WIDTH+1-bit adder/subtractor with carry-out.
  - Shared by the multiply accumulate step, the divide trial subtraction and the final two's-complement negation.
- The top level holds the FSM, counter and shift registers.

Test Plan:
- operandA=7, operandB=-3, ctrl_mult pulse at E0 -> result=0xFFFFFFEB, exception=0. result_ready is high only in the cycle after E0+33; busy is high for cycles E0+1..E0+32.
- operandA=-100, operandB=7, ctrl_div -> result=0xFFFFFFF2 (-14), exception=0, same latency.
- operandA=5, operandB=0, ctrl_div -> result=0, exception=1 after 33 cycles.
- operandA=0x00010000, operandB=0x00010000, ctrl_mult -> result=0x00000000.
  - exception=1 with MULTDIV_OVF_EXC_EN.
  - exception=0 without it.
- Start mult 6*7, pulse ctrl_div with new operands at cycle E0+10 -> pulse ignored; result=42 at E0+33. A ctrl_div 84/2 issued in the DONE cycle is accepted -> result=42 at 33 cycles later.
- Start div at E0, assert clear at E0+15 for one cycle -> outputs 0 immediately. No result_ready follows, and a new mult 3*3 returns 9.
